// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write/read arbiter.
// The state enum doubles as the command currently driven to the FIFO.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int DEPTH_DEF     = 16;
  localparam int RD_STARVE_DEF = 4;

  // Index width that stays at least one bit for a single requester.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_arb_if.sv
// Requester/consumer handshake and FIFO command bundle of the arbiter.
// master = requester/consumer side, slave = arbiter side.
interface fifo_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
);

  logic [NREQ-1:0]       req;
  logic [NREQ*DW-1:0]    req_data;
  logic [NREQ-1:0]       gnt;
  logic                  rd_req;
  logic                  rd_gnt;
  logic                  flush;
  logic                  fifo_rst;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [DW-1:0]         fifo_din;
  logic                  rd_valid;
  logic [$clog2(DEPTH):0] occ;

  modport master (
    output req, req_data, rd_req, flush,
    input  gnt, rd_gnt, fifo_rst, fifo_wr, fifo_rd, fifo_din, rd_valid, occ
  );

  modport slave (
    input  req, req_data, rd_req, flush,
    output gnt, rd_gnt, fifo_rst, fifo_wr, fifo_rd, fifo_din, rd_valid, occ
  );

endinterface

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// i_ptr, scanning upward modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int PW  = clog2_min1(NREQ),
  localparam int DWW = PW + 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_win,
  output logic            o_valid
);

  // Each requester's distance from the pointer; smallest asserted one wins.
  always_comb begin
    logic [DWW-1:0] v_best;
    logic [DWW-1:0] v_dist;
    o_win   = '0;
    o_valid = 1'b0;
    v_best  = '1;
    v_dist  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i >= int'(i_ptr)) v_dist = DWW'(i - int'(i_ptr));
      else                  v_dist = DWW'(i + NREQ - int'(i_ptr));
      if (i_req[i] && (v_dist < v_best)) begin
        v_best   = v_dist;
        o_win    = '0;
        o_win[i] = 1'b1;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_arb.sv
// Arbitrates NREQ writers and one reader onto a single-port FIFO command
// bus, tracking occupancy so the FIFO never overflows or underflows.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_IDLE  | no command driven this cycle
//   ST_WR    | fifo_wr driven with fifo_din
//   ST_RD    | fifo_rd driven; rd_valid follows next cycle
//   ST_FLUSH | fifo_rst driven for one cycle
module fifo_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RD_STARVE = RD_STARVE_DEF
) (
  input logic       clk,
  input logic       rst,
  fifo_arb_if.slave bus
);

  localparam int PW = clog2_min1(NREQ);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(RD_STARVE + 1);

  state_t          r_state;
  logic [OW-1:0]   r_occ;
  logic [PW-1:0]   r_ptr;
  logic [SW-1:0]   r_starve;
  logic [DW-1:0]   r_din;
  logic            r_rd_valid;
  logic            r_rst_hold;

  state_t          w_state_nxt;
  logic [OW-1:0]   w_occ_nxt;
  logic [PW-1:0]   w_ptr_nxt;
  logic [SW-1:0]   w_starve_nxt;
  logic [DW-1:0]   w_din_nxt;
  logic [NREQ-1:0] w_gnt;
  logic            w_rd_gnt;

  logic [NREQ-1:0] w_win;
  logic            w_win_vld;
  logic [PW-1:0]   w_win_idx;
  logic [DW-1:0]   w_win_data;
  logic            w_wr_elig;
  logic            w_rd_elig;
  logic            w_pick_wr;
  logic            w_pick_rd;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_win_vld)
  );

  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_win_idx  = PW'(i);
        w_win_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign w_wr_elig = w_win_vld && (r_occ < OW'(DEPTH));
  assign w_rd_elig = bus.rd_req && (r_occ != '0);
  assign w_pick_rd = w_rd_elig && (!w_wr_elig || (r_starve == SW'(RD_STARVE)));
  assign w_pick_wr = w_wr_elig && !w_pick_rd;

  always_comb begin
    w_state_nxt  = ST_IDLE;
    w_occ_nxt    = r_occ;
    w_ptr_nxt    = r_ptr;
    w_starve_nxt = '0;
    w_din_nxt    = r_din;
    w_gnt        = '0;
    w_rd_gnt     = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_FLUSH;
      w_occ_nxt   = '0;
      w_ptr_nxt   = '0;
    end else if (w_pick_rd) begin
      w_state_nxt = ST_RD;
      w_occ_nxt   = r_occ - OW'(1);
      w_rd_gnt    = 1'b1;
    end else if (w_pick_wr) begin
      w_state_nxt = ST_WR;
      w_occ_nxt   = r_occ + OW'(1);
      w_ptr_nxt   = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
      w_din_nxt   = w_win_data;
      w_gnt       = w_win;
      // Count writes that bypassed an eligible read; saturate at the limit.
      if (w_rd_elig)
        w_starve_nxt = (r_starve == SW'(RD_STARVE)) ? r_starve : r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_occ      <= '0;
      r_ptr      <= '0;
      r_starve   <= '0;
      r_din      <= '0;
      r_rd_valid <= 1'b0;
      r_rst_hold <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_occ      <= w_occ_nxt;
      r_ptr      <= w_ptr_nxt;
      r_starve   <= w_starve_nxt;
      r_din      <= w_din_nxt;
      r_rd_valid <= (r_state == ST_RD);
      r_rst_hold <= 1'b0;
    end
  end

  // Grants are combinational, so they are forced low while rst is asserted.
  assign bus.gnt      = rst ? w_gnt : '0;
  assign bus.rd_gnt   = rst & w_rd_gnt;
  assign bus.fifo_wr  = (r_state == ST_WR);
  assign bus.fifo_rd  = (r_state == ST_RD);
  assign bus.fifo_rst = r_rst_hold | (r_state == ST_FLUSH);
  assign bus.fifo_din = r_din;
  assign bus.rd_valid = r_rd_valid;
  assign bus.occ      = r_occ;

endmodule

// File: tb/tb_fifo_arb.sv
// Bench for fifo_arb: directed scenarios plus random traffic checked every
// cycle against a queue-based model of the arbiter and of the downstream FIFO.
module tb_fifo_arb;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int DEPTH     = 16;
  localparam int RD_STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_arb_if #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) bus ();

  fifo_arb #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .RD_STARVE(RD_STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: occupancy, pointer, starvation count, and what the
  // command bus must show in the current cycle.
  int          m_occ, m_ptr, m_starve;
  bit          m_wr, m_rd, m_fl, m_rdv, m_hold;
  logic [DW-1:0] m_din;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] fdout;

  int          c_win, c_idx;
  bit          c_wr_el, c_rd_el, c_do_rd, c_do_wr;
  logic [NREQ-1:0] c_gnt;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_gnt", bus.gnt, 0);
      check("rst_rd_gnt", bus.rd_gnt, 0);
      check("rst_fifo_wr", bus.fifo_wr, 0);
      check("rst_fifo_rd", bus.fifo_rd, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_fifo_din", bus.fifo_din, 0);
      check("rst_occ", bus.occ, 0);
      check("rst_fifo_rst", bus.fifo_rst, 1);
      m_occ = 0; m_ptr = 0; m_starve = 0;
      m_wr = 0; m_rd = 0; m_fl = 0; m_rdv = 0; m_hold = 1; m_din = '0;
      exp_q.delete(); exp_dout.delete(); fifo_q.delete(); fdout = '0;
    end else begin
      check("fifo_wr", bus.fifo_wr, m_wr);
      check("fifo_rd", bus.fifo_rd, m_rd);
      check("fifo_rst", bus.fifo_rst, m_fl | m_hold);
      check("rd_valid", bus.rd_valid, m_rdv);
      check("fifo_din", bus.fifo_din, m_din);
      check("occ", bus.occ, m_occ);
      check("wr_rd_overlap", bus.fifo_wr & bus.fifo_rd, 0);
      if (m_rdv) begin
        if (exp_dout.size() > 0) check("rd_data", fdout, exp_dout.pop_front());
        else check("rd_data_missing", 1, 0);
      end

      c_wr_el = (bus.req != '0) && (m_occ < DEPTH);
      c_rd_el = bus.rd_req && (m_occ > 0);
      c_do_rd = !bus.flush && c_rd_el && (!c_wr_el || m_starve == RD_STARVE);
      c_do_wr = !bus.flush && !c_do_rd && c_wr_el;
      c_win = -1;
      for (int k = 0; k < NREQ; k++) begin
        c_idx = (m_ptr + k) % NREQ;
        if (c_win < 0 && bus.req[c_idx]) c_win = c_idx;
      end
      c_gnt = '0;
      if (c_do_wr) c_gnt[c_win] = 1'b1;
      check("gnt", bus.gnt, c_gnt);
      check("rd_gnt", bus.rd_gnt, c_do_rd);

      // Downstream FIFO reacts to what the DUT drives this cycle.
      if (bus.fifo_rd) fdout = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
      if (bus.fifo_rst) fifo_q.delete();
      else if (bus.fifo_wr) fifo_q.push_back(bus.fifo_din);

      m_rdv = m_rd; m_wr = c_do_wr; m_rd = c_do_rd; m_fl = bus.flush; m_hold = 0;
      if (bus.flush) begin
        m_occ = 0; m_ptr = 0; m_starve = 0; exp_q.delete();
      end else if (c_do_rd) begin
        m_occ--; m_starve = 0;
        exp_dout.push_back(exp_q.pop_front());
      end else if (c_do_wr) begin
        m_occ++;
        m_ptr = (c_win + 1) % NREQ;
        m_din = bus.req_data[c_win*DW +: DW];
        exp_q.push_back(m_din);
        m_starve = c_rd_el ? ((m_starve < RD_STARVE) ? m_starve + 1 : RD_STARVE) : 0;
      end else begin
        m_starve = 0;
      end
    end
  end

  task automatic step(input logic [NREQ-1:0] r, input bit rd, input bit fl);
    @(posedge clk); #1;
    bus.req = r; bus.rd_req = rd; bus.flush = fl;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    int prd;
    bus.req = '0; bus.req_data = '0; bus.rd_req = 1'b0; bus.flush = 1'b0;
    rst = 1'b0;

    repeat (2) step(4'b1111, 1, 0);
    check("lit_rst_gnt", bus.gnt, 0);
    check("lit_rst_fifo_rst", bus.fifo_rst, 1);
    check("lit_rst_occ", bus.occ, 0);
    @(posedge clk); #1;
    rst = 1'b1; bus.req = '0; bus.rd_req = 1'b0;
    #1 check("lit_rst_hold", bus.fifo_rst, 1);

    // All four writers, no reader: strict rotation until the FIFO is full.
    for (int k = 0; k < 20; k++) begin
      step(4'b1111, 0, 0);
      check("s1_gnt", bus.gnt, (k < 16) ? (1 << (k % 4)) : 0);
      if (k >= 16) check("s1_occ", bus.occ, 16);
      if (k >= 17) check("s1_fifo_wr", bus.fifo_wr, 0);
    end

    // occ=8, one writer vs reader: 4 writes then 1 read.
    step(0, 0, 1);
    repeat (8) step(4'b0001, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(4'b0001, 1, 0);
      check("s2_gnt", bus.gnt, (k % 5 == 4) ? 0 : 1);
      check("s2_rd_gnt", bus.rd_gnt, (k % 5 == 4) ? 1 : 0);
    end

    // Empty FIFO ignores reads; one write of A5 then read it back.
    step(0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0);
      check("s3_no_rd_gnt", bus.rd_gnt, 0);
    end
    step(4'b0001, 0, 0);
    bus.req_data[DW-1:0] = 8'hA5;
    check("s3_gnt", bus.gnt, 1);
    step(0, 1, 0);
    check("s3_rd_gnt", bus.rd_gnt, 1);
    got = 0;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0);
      if (!got && bus.rd_valid) begin
        check("s3_dout", fdout, 8'hA5);
        got = 1;
      end
    end
    if (!got) check("s3_rd_valid_timeout", 0, 1);

    // Full FIFO: read wins first, then the write refills it.
    step(0, 0, 1);
    repeat (16) step(4'b0100, 0, 0);
    step(4'b0100, 1, 0);
    check("s4_rd_gnt_first", bus.rd_gnt, 1);
    check("s4_gnt_first", bus.gnt, 0);
    step(4'b0100, 1, 0);
    check("s4_gnt2", bus.gnt, 4'b0100);
    check("s4_rd_gnt2", bus.rd_gnt, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("s4_occ", bus.occ, 16);

    // Flush beats a pending write at occ=5.
    step(0, 0, 1);
    repeat (5) step(4'b0001, 0, 0);
    step(4'b0010, 0, 1);
    check("s5_gnt_flush", bus.gnt, 0);
    step(4'b0010, 0, 0);
    check("s5_fifo_rst", bus.fifo_rst, 1);
    check("s5_occ", bus.occ, 0);
    check("s5_gnt", bus.gnt, 4'b0010);
    step(0, 0, 0);
    check("s5_fifo_rst_once", bus.fifo_rst, 0);

    // Random traffic with varying read pressure, rare flushes and resets.
    for (int ph = 0; ph < 6; ph++) begin
      prd = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 400; c++) begin
        step(NREQ'($urandom), ($urandom_range(99) < prd), ($urandom_range(63) == 0));
        if ($urandom_range(299) == 0) begin
          #2 rst = 1'b0;
          repeat (2) step(NREQ'($urandom), $urandom_range(1) == 1, 0);
          rst = 1'b1;
        end
      end
    end

    // Reset in the middle of a write command.
    step(0, 0, 1);
    step(4'b1111, 0, 0);
    step(4'b1111, 0, 0);
    check("s6_wr_before", bus.fifo_wr, 1);
    #1 rst = 1'b0;
    #1;
    check("s6_gnt", bus.gnt, 0);
    check("s6_rd_gnt", bus.rd_gnt, 0);
    check("s6_fifo_wr", bus.fifo_wr, 0);
    check("s6_fifo_rd", bus.fifo_rd, 0);
    check("s6_rd_valid", bus.rd_valid, 0);
    check("s6_fifo_din", bus.fifo_din, 0);
    check("s6_occ", bus.occ, 0);
    check("s6_fifo_rst", bus.fifo_rst, 1);
    step(0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 0, 0);
    check("s6_occ_after", bus.occ, 0);
    check("s6_fifo_rst_after", bus.fifo_rst, 0);
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
